// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the LEGv8 core.
// Holds the PC, addresses the 64x32 instruction ROM, registers the fetched
// word and presents {instr, pc} to decode over a valid/ready handshake.
// Handles branch redirects, halts on the halt word, faults on misaligned
// targets and counts instructions accepted by decode.
module fetch_unit #(
    parameter int          N         = 64,
    parameter int          AW        = 6,
    parameter logic [31:0] HALT_WORD = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_q,
    input  logic          br_taken,
    input  logic [N-1:0]  br_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [N-1:0]  out_pc,
    output logic          halted,
    output logic          fault,
    output logic [31:0]   fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t        state_q,       state_d;
    logic [N-1:0]  pc_q,          pc_d;
    logic          out_valid_q,   out_valid_d;
    logic [31:0]   out_instr_q,   out_instr_d;
    logic [N-1:0]  out_pc_q,      out_pc_d;
    logic          halted_q,      halted_d;
    logic          fault_q,       fault_d;
    logic [31:0]   fetch_count_q, fetch_count_d;

    logic accept;
    logic load;

    // Handshake: a word leaves on accept; a new one may enter when the
    // output register is empty or being emptied on this same edge.
    assign accept = out_valid_q & out_ready;
    assign load   = (state_q == S_FETCH) & (~out_valid_q | out_ready);

    // ROM word address; upper PC bits are ignored so addressing wraps.
    assign imem_addr = pc_q[AW+1:2];

    // Next-state logic: redirect beats fetch; the accept count is independent.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        fetch_count_d = fetch_count_q + 32'(accept);

        if (br_taken && (state_q != S_FAULT)) begin
            // Any redirect flushes the held word; a same-edge accept still counts.
            out_valid_d = 1'b0;
            if (br_target[1:0] == 2'b00) begin
                pc_d    = br_target;
                state_d = S_FETCH;
            end else begin
                state_d = S_FAULT;
            end
        end else if (load) begin
            if (imem_q != HALT_WORD) begin
                out_instr_d = imem_q;
                out_pc_d    = pc_q;
                out_valid_d = 1'b1;
                pc_d        = pc_q + N'(4);
            end else begin
                out_valid_d = 1'b0;
                state_d     = S_HALT;
            end
        end

        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);
    end

    // State register with synchronous active-low reset; reset discards any held word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d from before the edge, independent of statement order.
        if (!reset) begin
            state_q       <= S_FETCH;
            pc_q          <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure, redirect,
// halt and resume, misaligned-target fault, counter wrap and address wrap.
module tb_fetch_unit;

    localparam int N  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic          br_taken;
    logic [N-1:0]  br_target;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [N-1:0]  out_pc;
    logic          halted;
    logic          fault;
    logic [31:0]   fetch_count;

    logic [31:0] rom [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_q = rom[imem_addr];

    fetch_unit #(.N(N), .AW(AW), .HALT_WORD(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h8B00_0000 | 32'(i);
        rom[0]  = 32'hF800_0000;
        rom[1]  = 32'hF800_8001;
        rom[2]  = 32'hF801_0002;
        rom[34] = 32'h0000_0000;

        reset     = 1'b0;
        out_ready = 1'b1;
        br_taken  = 1'b0;
        br_target = '0;

        // Reset state
        tick();
        check("rst_valid",  64'(out_valid),   64'd0);
        check("rst_pc",     out_pc,           64'd0);
        check("rst_instr",  64'(out_instr),   64'd0);
        check("rst_halted", 64'(halted),      64'd0);
        check("rst_fault",  64'(fault),       64'd0);
        check("rst_count",  64'(fetch_count), 64'd0);
        check("rst_addr",   64'(imem_addr),   64'd0);

        // Edge 1: first word valid with out_pc=0
        reset = 1'b1;
        tick();
        check("e1_valid", 64'(out_valid), 64'd1);
        check("e1_pc",    out_pc,         64'h0);
        check("e1_instr", 64'(out_instr), 64'hF800_0000);
        check("e1_count", 64'(fetch_count), 64'd0);

        // Edge 2: back-to-back, word 0 accepted
        tick();
        check("e2_pc",    out_pc,           64'h4);
        check("e2_instr", 64'(out_instr),   64'hF800_8001);
        check("e2_count", 64'(fetch_count), 64'd1);

        // Back-pressure for 3 cycles: word at pc=4 stays, pc stays 8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",    out_pc,           64'h4);
            check("stall_instr", 64'(out_instr),   64'hF800_8001);
            check("stall_addr",  64'(imem_addr),   64'd2);
            check("stall_count", 64'(fetch_count), 64'd1);
        end

        // Release: pc=8 follows on the next edge
        out_ready = 1'b1;
        tick();
        check("rel_pc",    out_pc,           64'h8);
        check("rel_instr", 64'(out_instr),   64'hF801_0002);
        check("rel_count", 64'(fetch_count), 64'd2);
        tick();
        check("rel2_pc",    out_pc,           64'hC);
        check("rel2_count", 64'(fetch_count), 64'd3);

        // Redirect to 0x2C on the same edge as an accept
        br_taken  = 1'b1;
        br_target = 64'h2C;
        tick();
        br_taken = 1'b0;
        check("br_count", 64'(fetch_count), 64'd4);
        check("br_valid", 64'(out_valid),   64'd0);
        check("br_addr",  64'(imem_addr),   64'd11);
        tick();
        check("br2_valid", 64'(out_valid),   64'd1);
        check("br2_pc",    out_pc,           64'h2C);
        check("br2_instr", 64'(out_instr),   64'h8B00_000B);
        check("br2_count", 64'(fetch_count), 64'd4);

        // Stream words 12..33, then hit the halt word at ROM[34]
        repeat (22) tick();
        check("pre_halt_pc",    out_pc,         64'h84);
        check("pre_halt_valid", 64'(out_valid), 64'd1);
        tick();
        check("halt_halted", 64'(halted),      64'd1);
        check("halt_valid",  64'(out_valid),   64'd0);
        check("halt_count",  64'(fetch_count), 64'd27);
        check("halt_addr",   64'(imem_addr),   64'd34);
        repeat (3) tick();
        check("halt_hold_halted", 64'(halted),      64'd1);
        check("halt_hold_valid",  64'(out_valid),   64'd0);
        check("halt_hold_count",  64'(fetch_count), 64'd27);

        // Resume from HALT via redirect to 0x8
        br_taken  = 1'b1;
        br_target = 64'h8;
        tick();
        br_taken = 1'b0;
        check("resume_halted", 64'(halted),    64'd0);
        check("resume_valid",  64'(out_valid), 64'd0);
        tick();
        check("resume2_valid", 64'(out_valid), 64'd1);
        check("resume2_pc",    out_pc,         64'h8);
        check("resume2_instr", 64'(out_instr), 64'hF801_0002);

        // Misaligned target 0x6: fault, accept still counts, pc unchanged (0xC)
        br_taken  = 1'b1;
        br_target = 64'h6;
        tick();
        check("fault_fault", 64'(fault),       64'd1);
        check("fault_valid", 64'(out_valid),   64'd0);
        check("fault_count", 64'(fetch_count), 64'd28);
        check("fault_addr",  64'(imem_addr),   64'd3);
        br_target = 64'h10;
        tick();
        br_taken = 1'b0;
        check("fault_ign_fault", 64'(fault),     64'd1);
        check("fault_ign_valid", 64'(out_valid), 64'd0);
        check("fault_ign_addr",  64'(imem_addr), 64'd3);

        // One reset edge clears the fault and restarts at pc=0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("clr_fault", 64'(fault),       64'd0);
        check("clr_count", 64'(fetch_count), 64'd0);
        check("clr_addr",  64'(imem_addr),   64'd0);
        tick();
        check("restart_valid", 64'(out_valid), 64'd1);
        check("restart_pc",    out_pc,         64'h0);

        // Counter wrap: preload 0xFFFFFFFF while stalled, then one accept
        out_ready = 1'b0;
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.fetch_count_q;
        #1;
        check("preload_count", 64'(fetch_count), 64'hFFFF_FFFF);
        out_ready = 1'b1;
        tick();
        check("wrap_count", 64'(fetch_count), 64'd0);

        // Address wrap: pc 0xFC -> 0x100 addresses ROM word 0
        br_taken  = 1'b1;
        br_target = 64'hFC;
        tick();
        br_taken = 1'b0;
        check("awrap_addr63", 64'(imem_addr), 64'd63);
        tick();
        check("awrap_pc",    out_pc,         64'hFC);
        check("awrap_addr0", 64'(imem_addr), 64'd0);
        tick();
        check("awrap2_pc",    out_pc,       64'h100);
        check("awrap2_instr", 64'(out_instr), 64'hF800_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
